// File: rtl/mxu_pkg.sv
// rtl/mxu_pkg.sv - shared MXU constants and weight-loader state type
package mxu_pkg;

  localparam int MXU_ROWS   = 4;
  localparam int MXU_COLS   = 4;
  localparam int MXU_DATA_W = 8;
  localparam int MXU_Y_W    = 8;

  // Target index no PE row ever matches; used to mask stall cycles.
  localparam logic [MXU_Y_W-1:0] SENTINEL = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FIN  = 2'd2
  } load_state_e;

endpackage

// File: rtl/mxu_weight_loader.sv
// rtl/mxu_weight_loader.sv - sequences one ROWS-deep weight load into the MXU array
module mxu_weight_loader
  import mxu_pkg::*;
#(
  parameter int ROWS   = MXU_ROWS,
  parameter int COLS   = MXU_COLS,
  parameter int DATA_W = MXU_DATA_W,
  parameter int Y_W    = MXU_Y_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   w_valid,
  output logic                   w_ready,
  input  logic [COLS*DATA_W-1:0] w_data,
  output logic                   load_phase,
  output logic [Y_W-1:0]         load_weight_target_y,
  output logic [COLS*DATA_W-1:0] load_weight,
  output logic                   busy,
  output logic                   done
);

  localparam logic [Y_W-1:0] NO_ROW   = {Y_W{1'b1}};
  localparam logic [Y_W-1:0] LAST_ROW = Y_W'(ROWS - 1);

  load_state_e    state;
  logic [Y_W-1:0] row_cnt;
  logic           accept;

  assign w_ready = (state == ST_LOAD) && !abort;
  assign accept  = w_ready && w_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= ST_IDLE;
      row_cnt              <= '0;
      load_phase           <= 1'b0;
      load_weight_target_y <= '0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          load_phase           <= 1'b0;
          load_weight_target_y <= '0;
          row_cnt              <= '0;
          if (start && !abort) begin
            state <= ST_LOAD;
            busy  <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (abort) begin
            state                <= ST_IDLE;
            load_phase           <= 1'b0;
            load_weight_target_y <= '0;
            busy                 <= 1'b0;
            row_cnt              <= '0;
          end else begin
            load_phase <= 1'b1;
            if (accept) begin
              load_weight_target_y <= row_cnt;
              row_cnt              <= row_cnt + Y_W'(1);
              if (row_cnt == LAST_ROW) state <= ST_FIN;
            end else begin
              load_weight_target_y <= NO_ROW;
            end
          end
        end
        ST_FIN: begin
          state                <= ST_IDLE;
          load_phase           <= 1'b0;
          load_weight_target_y <= '0;
          busy                 <= 1'b0;
          row_cnt              <= '0;
          done                 <= !abort;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Lanes only move on an accepted beat, so stall cycles hold the last row.
  for (genvar c = 0; c < COLS; c++) begin : g_lane
    logic [DATA_W-1:0] lane_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lane_q <= '0;
      else if (accept) lane_q <= w_data[c*DATA_W +: DATA_W];
    end
    assign load_weight[c*DATA_W +: DATA_W] = lane_q;
  end

endmodule
